// File: rtl/xor_pkg.sv
// Shared constants for the XOR descrambler: default word width, feedback
// taps and the width of the saturating bit counter used for lock detection.
package xor_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_TAP_A = 6;
  localparam int DEF_TAP_B = 7;

  // Counter must represent 0..tap_b inclusive (it saturates at tap_b).
  function automatic int cnt_width(input int tap_b);
    return $clog2(tap_b + 1);
  endfunction

  localparam int CNT_W = $clog2(DEF_TAP_B + 1);

endpackage

// File: rtl/xor_descramble_word.sv
// Combinational descrambling of one WIDTH-bit word. Bit 0 is the earliest
// bit in time, so the history is advanced LSB first. The history is always
// fed with the received (scrambled) bit, which is what makes the
// descrambler self-synchronising.
module xor_descramble_word
  import xor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAP_A = DEF_TAP_A,
  parameter int TAP_B = DEF_TAP_B
) (
  input  logic [WIDTH-1:0] d_in,
  input  logic [TAP_B-1:0] s_in,
  output logic [WIDTH-1:0] d_out,
  output logic [TAP_B-1:0] s_out
);

  logic [TAP_B-1:0] sh;

  // Walk the word bit by bit, XOR-ing with both taps before shifting in the received bit.
  always_comb begin
    sh    = s_in;
    d_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d_out[i] = d_in[i] ^ sh[TAP_A-1] ^ sh[TAP_B-1];
      sh       = {sh[TAP_B-2:0], d_in[i]};
    end
    s_out = sh;
  end

endmodule

// File: rtl/xor_descrambler.sv
// Self-synchronising multiplicative descrambler (1 + x^TAP_A + x^TAP_B) on a
// valid/ready stream. One output register stage; history and lock counter
// advance only when a word is accepted.
module xor_descrambler
  import xor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAP_A = DEF_TAP_A,
  parameter int TAP_B = DEF_TAP_B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_locked
);

  localparam int CW = cnt_width(TAP_B);

  logic [TAP_B-1:0] s_reg;
  logic [TAP_B-1:0] s_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] desc_word;
  logic             out_valid_reg;
  logic             out_locked_reg;
  logic             locked_now;
  logic             accept;
  int               cnt_sum;

  xor_descramble_word #(
    .WIDTH(WIDTH),
    .TAP_A(TAP_A),
    .TAP_B(TAP_B)
  ) u_word (
    .d_in (in_data),
    .s_in (s_reg),
    .d_out(desc_word),
    .s_out(s_next)
  );

  // The output slot can take a new word when it is empty or being drained this cycle.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Lock decision uses the count before this word; the count then saturates at TAP_B.
  always_comb begin
    locked_now = (int'(cnt_reg) >= TAP_B);
    cnt_sum    = int'(cnt_reg) + WIDTH;
    if (cnt_sum >= TAP_B) begin
      cnt_next = CW'(TAP_B);
    end else begin
      cnt_next = CW'(cnt_sum);
    end
  end

  // Output register, history and lock counter; rst and clr both flush everything.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s_reg          <= '0;
      cnt_reg        <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_locked_reg <= 1'b0;
    end else if (accept) begin
      s_reg          <= s_next;
      cnt_reg        <= cnt_next;
      out_data_reg   <= desc_word;
      out_valid_reg  <= 1'b1;
      out_locked_reg <= locked_now;
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign out_locked = out_locked_reg;

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler (WIDTH=5, taps 6/7). Inputs change 1 ns
// after the rising edge; outputs are checked 1 ns after the edge.
module tb_xor_descrambler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_locked;

  int total = 0;
  int bad = 0;

  xor_descrambler #(.WIDTH(5), .TAP_A(6), .TAP_B(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_locked(out_locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference transmit scrambler: y = x ^ t[5] ^ t[6], scrambled bit enters history.
  task automatic scramble(input logic [4:0] p, input logic [6:0] st,
                          output logic [4:0] y, output logic [6:0] st_o);
    logic [6:0] t;
    t = st;
    y = '0;
    for (int i = 0; i < 5; i++) begin
      y[i] = p[i] ^ t[5] ^ t[6];
      t    = {t[5:0], y[i]};
    end
    st_o = t;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++;
    if (out_data !== 5'b00000) begin bad++; $display("FAIL reset_data got=%b want=00000", out_data); end
    total++;
    if (out_locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", out_locked); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    $display("reset: valid=%b data=%b locked=%b in_ready=%b", out_valid, out_data, out_locked, in_ready);
  endtask

  task automatic test_zeros_lock();
    logic [2:0] exp_lock;
    exp_lock = 3'b100;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 5'b00000;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 5'b00000 || out_locked !== exp_lock[k]) begin
        bad++;
        $display("FAIL zeros_word%0d got v=%b d=%b l=%b want v=1 d=00000 l=%b",
                 k, out_valid, out_data, out_locked, exp_lock[k]);
      end
      $display("zeros word %0d: out=%b locked=%b", k, out_data, out_locked);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL zeros_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_feedback();
    logic [4:0] ins [2];
    logic [4:0] exps [2];
    ins[0] = 5'b00001; exps[0] = 5'b00001;
    ins[1] = 5'b00000; exps[1] = 5'b00110;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = ins[k];
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== exps[k]) begin
        bad++;
        $display("FAIL feedback_word%0d got v=%b d=%b want v=1 d=%b", k, out_valid, out_data, exps[k]);
      end
      $display("feedback word %0d: in=%b out=%b", k, ins[k], out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'b00001;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 5'b00001 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_first got v=%b d=%b rdy=%b want v=1 d=00001 rdy=0", out_valid, out_data, in_ready);
    end
    in_data = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 5'b00001 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%b d=%b rdy=%b want v=1 d=00001 rdy=0",
                 c, out_valid, out_data, in_ready);
      end
      $display("stall cycle %0d: out=%b in_ready=%b", c, out_data, in_ready);
    end
    out_ready = 1'b1;
    in_data   = 5'b00000;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 5'b00110) begin
      bad++;
      $display("FAIL stall_next got v=%b d=%b want v=1 d=00110", out_valid, out_data);
    end
    $display("stall release: out=%b", out_data);
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 5'b00110) begin
      bad++;
      $display("FAIL stall_drain got v=%b d=%b want v=0 d=00110", out_valid, out_data);
    end
  endtask

  task automatic test_reference();
    logic [6:0] st;
    logic [4:0] p;
    logic [4:0] y;
    logic       exp_l;
    do_reset();
    out_ready = 1'b1;
    st = 7'h5A;
    for (int k = 0; k < 20; k++) begin
      p = 5'($urandom_range(0, 31));
      scramble(p, st, y, st);
      in_valid = 1'b1;
      in_data  = y;
      tick();
      exp_l = (k >= 2);
      total++;
      if (out_valid !== 1'b1 || out_locked !== exp_l || (exp_l && out_data !== p)) begin
        bad++;
        $display("FAIL ref_word%0d got v=%b d=%b l=%b want v=1 d=%b l=%b",
                 k, out_valid, out_data, out_locked, p, exp_l);
      end
      $display("ref word %0d: plain=%b scr=%b out=%b locked=%b", k, p, y, out_data, out_locked);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    logic [4:0] ins [3];
    ins[0] = 5'b10110; ins[1] = 5'b01101; ins[2] = 5'b11011;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = ins[k];
      tick();
    end
    total++;
    if (out_locked !== 1'b1) begin bad++; $display("FAIL clr_prelock got=%b want=1", out_locked); end
    clr      = 1'b1;
    in_data  = 5'b11100;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_locked !== 1'b0) begin
      bad++;
      $display("FAIL clr_flush got v=%b l=%b want v=0 l=0", out_valid, out_locked);
    end
    $display("clr: valid=%b locked=%b", out_valid, out_locked);
    in_valid = 1'b1;
    in_data  = 5'b10101;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 5'b10101 || out_locked !== 1'b0) begin
      bad++;
      $display("FAIL clr_after got v=%b d=%b l=%b want v=1 d=10101 l=0", out_valid, out_data, out_locked);
    end
    $display("after clr: out=%b locked=%b", out_data, out_locked);
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [6:0] st;
    logic [4:0] p;
    logic [4:0] y;
    do_reset();
    out_ready = 1'b1;
    st = 7'h00;
    for (int k = 0; k < 10; k++) begin
      p = 5'((k * 7 + 3) % 32);
      scramble(p, st, y, st);
      in_valid = 1'b1;
      in_data  = y;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== p) begin
        bad++;
        $display("FAIL b2b_word%0d got v=%b d=%b want v=1 d=%b", k, out_valid, out_data, p);
      end
      $display("b2b word %0d: scr=%b out=%b", k, y, out_data);
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_zeros_lock();
    test_feedback();
    test_stall();
    test_reference();
    test_clear();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
